// File: rtl/service_4_alarm_sequencer.sv
// Alarm sequencer: arms on alarm_en, rings on a time match, then runs a
// multi-round switch-matching minigame before dismissing the alarm.
// Latency: match -> ringing 1 cycle; hit -> new pattern 1 cycle.
// Backpressure: none; all inputs are level or single-cycle pulses sampled every clk.
//
// Ports:
//   clk, resetn      clock, asynchronous active-low reset
//   tick_1s          one-cycle pulse per second (round timeout, snooze timing)
//   alarm_en         alarm enable switch level; low forces IDLE
//   current, alarm   current time and alarm time, compared for equality
//   push_m, snooze   debounced single-cycle button pulses
//   spdts            user switch bank compared against random_led in GAME
//   alarm_state      000 IDLE, 001 ARMED, 010 RING, 100 GAME, 011 SNOOZE
//   random_led       target pattern during GAME, 0 otherwise
//   ringing          buzzer enable, high only in RING
//   round_cnt        matches completed in the current game
//   dismissed        one-cycle pulse when the final round is matched
//
// Optional feature macro: SERVICE_4_SNOOZE_EN adds the SNOOZE state and its
// 9-bit tick counter. Without it the snooze input is unused.
module service_4_alarm_sequencer #(
  parameter int unsigned ROUNDS        = 3,
  parameter int unsigned ROUND_TIMEOUT = 10,
  parameter int unsigned SNOOZE_TICKS  = 300,
  parameter logic [9:0]  LFSR_SEED     = 10'h2A5
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        tick_1s,
  input  logic        alarm_en,
  input  logic [15:0] current,
  input  logic [15:0] alarm,
  input  logic        push_m,
  input  logic        snooze,
  input  logic [9:0]  spdts,
  output logic [2:0]  alarm_state,
  output logic [9:0]  random_led,
  output logic        ringing,
  output logic [3:0]  round_cnt,
  output logic        dismissed
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_ARMED  = 3'b001,
    ST_RING   = 3'b010,
    ST_SNOOZE = 3'b011,
    ST_GAME   = 3'b100
  } state_t;

  localparam logic [3:0] ROUNDS_L  = 4'(ROUNDS);
  localparam logic [7:0] TIMEOUT_L = 8'(ROUND_TIMEOUT);

  state_t      state_q, state_d;
  logic [9:0]  lfsr_q, lfsr_d;
  logic [9:0]  random_led_q, random_led_d;
  logic [3:0]  round_cnt_q, round_cnt_d;
  logic [7:0]  timeout_q, timeout_d;
  logic        fired_q, fired_d;
  logic        dismissed_q, dismissed_d;

  logic        match;
  logic        hit;
  logic [3:0]  round_inc;
  logic [7:0]  timeout_inc;

`ifdef SERVICE_4_SNOOZE_EN
  localparam logic [8:0] SNOOZE_L = 9'(SNOOZE_TICKS);
  logic [8:0]  snooze_cnt_q, snooze_cnt_d;
  logic [8:0]  snooze_inc;
`else
  logic        unused_snooze;
  assign unused_snooze = snooze ^ (SNOOZE_TICKS == 0);
`endif

  assign match       = (current == alarm);
  assign hit         = (spdts == random_led_q);
  assign round_inc   = round_cnt_q + 4'd1;
  // Saturating increment so the counter can never wrap past the limit.
  assign timeout_inc = (timeout_q >= TIMEOUT_L) ? TIMEOUT_L : (timeout_q + 8'd1);
`ifdef SERVICE_4_SNOOZE_EN
  assign snooze_inc  = snooze_cnt_q + 9'd1;
`endif

  always_comb begin
    state_d      = state_q;
    random_led_d = random_led_q;
    round_cnt_d  = round_cnt_q;
    timeout_d    = timeout_q;
    dismissed_d  = 1'b0;
    fired_d      = fired_q;
`ifdef SERVICE_4_SNOOZE_EN
    snooze_cnt_d = snooze_cnt_q;
`endif
    // Taps 10 and 7: x^10 + x^7 + 1 is primitive, so a nonzero seed never hits 0.
    lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};

    // The latch only survives while the matching minute lasts; set (below) wins.
    if (!match || !alarm_en) begin
      fired_d = 1'b0;
    end

    if (!alarm_en) begin
      state_d      = ST_IDLE;
      random_led_d = '0;
      round_cnt_d  = '0;
      timeout_d    = '0;
`ifdef SERVICE_4_SNOOZE_EN
      snooze_cnt_d = '0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_ARMED;
        end

        ST_ARMED: begin
          if (match && !fired_q) begin
            state_d = ST_RING;
          end
        end

        ST_RING: begin
          // push_m takes priority over snooze when both arrive together.
          if (push_m) begin
            state_d      = ST_GAME;
            random_led_d = lfsr_q;
            round_cnt_d  = '0;
            timeout_d    = '0;
          end
`ifdef SERVICE_4_SNOOZE_EN
          else if (snooze) begin
            state_d      = ST_SNOOZE;
            snooze_cnt_d = '0;
          end
`endif
        end

`ifdef SERVICE_4_SNOOZE_EN
        ST_SNOOZE: begin
          if (tick_1s) begin
            if (snooze_inc >= SNOOZE_L) begin
              state_d      = ST_RING;
              snooze_cnt_d = '0;
            end else begin
              snooze_cnt_d = snooze_inc;
            end
          end
        end
`endif

        ST_GAME: begin
          // A hit on the same edge as a tick beats the timeout.
          if (hit) begin
            timeout_d = '0;
            if (round_inc == ROUNDS_L) begin
              state_d      = ST_ARMED;
              dismissed_d  = 1'b1;
              fired_d      = 1'b1;
              random_led_d = '0;
              round_cnt_d  = '0;
            end else begin
              round_cnt_d  = round_inc;
              random_led_d = lfsr_q;
            end
          end else if (tick_1s) begin
            if (timeout_inc == TIMEOUT_L) begin
              state_d      = ST_RING;
              round_cnt_d  = '0;
              random_led_d = '0;
              timeout_d    = '0;
            end else begin
              timeout_d = timeout_inc;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      lfsr_q       <= LFSR_SEED;
      random_led_q <= '0;
      round_cnt_q  <= '0;
      timeout_q    <= '0;
      fired_q      <= 1'b0;
      dismissed_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      random_led_q <= random_led_d;
      round_cnt_q  <= round_cnt_d;
      timeout_q    <= timeout_d;
      fired_q      <= fired_d;
      dismissed_q  <= dismissed_d;
    end
  end

`ifdef SERVICE_4_SNOOZE_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      snooze_cnt_q <= '0;
    end else begin
      snooze_cnt_q <= snooze_cnt_d;
    end
  end
`endif

  assign alarm_state = state_q;
  assign random_led  = random_led_q;
  assign ringing     = (state_q == ST_RING);
  assign round_cnt   = round_cnt_q;
  assign dismissed   = dismissed_q;

endmodule

// File: tb/tb_service_4_alarm_sequencer.sv
// Directed bench for service_4_alarm_sequencer with ROUNDS=3,
// ROUND_TIMEOUT=10, SNOOZE_TICKS=5. Inputs change 1 ns after the rising
// edge and outputs are checked there; expected patterns come from a local LFSR.
module tb_service_4_alarm_sequencer;

  logic        clk;
  logic        resetn;
  logic        tick_1s;
  logic        alarm_en;
  logic [15:0] current;
  logic [15:0] alarm;
  logic        push_m;
  logic        snooze;
  logic [9:0]  spdts;
  logic [2:0]  alarm_state;
  logic [9:0]  random_led;
  logic        ringing;
  logic [3:0]  round_cnt;
  logic        dismissed;

  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] m_lfsr;
  logic [9:0] exp_led;

  service_4_alarm_sequencer #(
    .ROUNDS(3), .ROUND_TIMEOUT(10), .SNOOZE_TICKS(5), .LFSR_SEED(10'h2A5)
  ) dut (
    .clk(clk), .resetn(resetn), .tick_1s(tick_1s), .alarm_en(alarm_en),
    .current(current), .alarm(alarm), .push_m(push_m), .snooze(snooze),
    .spdts(spdts), .alarm_state(alarm_state), .random_led(random_led),
    .ringing(ringing), .round_cnt(round_cnt), .dismissed(dismissed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: Fibonacci, taps 10 and 7, reloads the seed on reset.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) m_lfsr <= 10'h2A5;
    else         m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // n tick pulses, each followed by an idle cycle.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1s = 1'b1;
      cyc();
      tick_1s = 1'b0;
      cyc();
    end
  endtask

  task automatic press_m();
    exp_led = m_lfsr;
    push_m = 1'b1;
    cyc();
    push_m = 1'b0;
  endtask

  task automatic do_hit();
    spdts   = random_led;
    exp_led = m_lfsr;
    cyc();
    spdts = '0;
  endtask

  initial begin
    resetn = 1'b0; tick_1s = 1'b0; alarm_en = 1'b0; current = 16'h0000;
    alarm = 16'h0000; push_m = 1'b0; snooze = 1'b0; spdts = '0;
    cyc(); cyc();
    chk("rst_state", 16'(alarm_state), 16'h0);
    chk("rst_ring", 16'(ringing), 16'h0);
    chk("rst_led", 16'(random_led), 16'h0);
    chk("rst_round", 16'(round_cnt), 16'h0);
    chk("rst_dism", 16'(dismissed), 16'h0);
    resetn = 1'b1;
    cyc();
    chk("idle_noen", 16'(alarm_state), 16'h0);

    // Arm and fire on 07:29 -> 07:30
    alarm_en = 1'b1; alarm = 16'h0730; current = 16'h0729;
    cyc();
    chk("armed", 16'(alarm_state), 16'h1);
    cyc(); cyc();
    chk("armed_nomatch", 16'(ringing), 16'h0);
    current = 16'h0730;
    cyc();
    chk("ring_state", 16'(alarm_state), 16'h2);
    chk("ring_buzz", 16'(ringing), 16'h1);

    // Snooze behaviour depends on the build
    snooze = 1'b1;
    cyc();
    snooze = 1'b0;
`ifdef SERVICE_4_SNOOZE_EN
    chk("snooze_state", 16'(alarm_state), 16'h3);
    chk("snooze_quiet", 16'(ringing), 16'h0);
    ticks(4);
    chk("snooze_4tick", 16'(alarm_state), 16'h3);
    ticks(1);
    chk("snooze_back", 16'(alarm_state), 16'h2);
`else
    chk("nosnooze_state", 16'(alarm_state), 16'h2);
    chk("nosnooze_buzz", 16'(ringing), 16'h1);
`endif

    // Enter the game
    press_m();
    chk("game_state", 16'(alarm_state), 16'h4);
    chk("game_led", 16'(random_led), 16'(exp_led));
    chk("game_led_nz", 16'(random_led != 0), 16'h1);
    chk("game_quiet", 16'(ringing), 16'h0);
    chk("game_round0", 16'(round_cnt), 16'h0);

    do_hit();
    chk("hit1_round", 16'(round_cnt), 16'h1);
    chk("hit1_led", 16'(random_led), 16'(exp_led));
    do_hit();
    chk("hit2_round", 16'(round_cnt), 16'h2);
    chk("hit2_led", 16'(random_led), 16'(exp_led));
    do_hit();
    chk("hit3_dism", 16'(dismissed), 16'h1);
    chk("hit3_state", 16'(alarm_state), 16'h1);
    chk("hit3_led", 16'(random_led), 16'h0);
    chk("hit3_round", 16'(round_cnt), 16'h0);
    cyc();
    chk("dism_pulse", 16'(dismissed), 16'h0);

    // Same minute must not re-ring
    repeat (100) cyc();
    chk("no_rering", 16'(alarm_state), 16'h1);
    current = 16'h0731;
    cyc();
    chk("next_min", 16'(alarm_state), 16'h1);
    current = 16'h0730;
    cyc();
    chk("rering", 16'(alarm_state), 16'h2);

    // Timeout: one hit, then 10 ticks with no hit
    press_m();
    chk("to_game", 16'(alarm_state), 16'h4);
    do_hit();
    chk("to_hit", 16'(round_cnt), 16'h1);
    ticks(9);
    chk("to_9ticks", 16'(alarm_state), 16'h4);
    ticks(1);
    chk("to_state", 16'(alarm_state), 16'h2);
    chk("to_round", 16'(round_cnt), 16'h0);
    chk("to_led", 16'(random_led), 16'h0);

    // Hit coincident with the 10th tick keeps the game going
    press_m();
    ticks(9);
    chk("co_9ticks", 16'(alarm_state), 16'h4);
    tick_1s = 1'b1;
    do_hit();
    tick_1s = 1'b0;
    chk("co_state", 16'(alarm_state), 16'h4);
    chk("co_round", 16'(round_cnt), 16'h1);
    chk("co_led", 16'(random_led), 16'(exp_led));
    ticks(9);
    chk("co_tmo_clear", 16'(alarm_state), 16'h4);
    ticks(1);
    chk("co_tmo_fire", 16'(alarm_state), 16'h2);

    // alarm_en drop in RING
    alarm_en = 1'b0;
    cyc();
    chk("drop_ring_st", 16'(alarm_state), 16'h0);
    chk("drop_ring_bz", 16'(ringing), 16'h0);
    alarm_en = 1'b1;
    cyc();
    chk("rearm", 16'(alarm_state), 16'h1);
    cyc();
    chk("rering2", 16'(alarm_state), 16'h2);

    // alarm_en drop in GAME
    press_m();
    do_hit();
    chk("drop_pre", 16'(round_cnt), 16'h1);
    alarm_en = 1'b0;
    cyc();
    chk("drop_game_st", 16'(alarm_state), 16'h0);
    chk("drop_game_led", 16'(random_led), 16'h0);
    chk("drop_game_rnd", 16'(round_cnt), 16'h0);

    // push_m and snooze together: push_m wins; push_m ignored inside GAME
    alarm_en = 1'b1;
    cyc(); cyc();
    chk("both_pre", 16'(alarm_state), 16'h2);
    snooze = 1'b1;
    press_m();
    snooze = 1'b0;
    chk("both_game", 16'(alarm_state), 16'h4);
    chk("both_led", 16'(random_led), 16'(exp_led));
    exp_led = random_led;
    push_m = 1'b1;
    cyc();
    push_m = 1'b0;
    chk("pm_ign_st", 16'(alarm_state), 16'h4);
    chk("pm_ign_led", 16'(random_led), 16'(exp_led));

    // Reset mid-game at round 2, off-edge
    do_hit();
    do_hit();
    chk("mid_round2", 16'(round_cnt), 16'h2);
    #2;
    resetn = 1'b0;
    #1;
    chk("mrst_state", 16'(alarm_state), 16'h0);
    chk("mrst_led", 16'(random_led), 16'h0);
    chk("mrst_round", 16'(round_cnt), 16'h0);
    chk("mrst_ring", 16'(ringing), 16'h0);
    chk("mrst_dism", 16'(dismissed), 16'h0);
    #2;
    resetn = 1'b1;
    cyc();
    chk("post_rst_arm", 16'(alarm_state), 16'h1);
    cyc();
    chk("post_rst_ring", 16'(alarm_state), 16'h2);
    press_m();
    chk("post_rst_led", 16'(random_led), 16'(exp_led));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
